// File: rtl/wisc_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, the EPC and the I-cache request
// handshake, and produces the IF/ID payload (inst, pc+2, valid).
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_stall                   decode hazard stall (hold IF/ID and PC)
//   i_redirect, i_redirect_pc taken branch/jump and its target
//   i_exception               SIIC decoded (fetch from EXC_VECTOR, save EPC)
//   i_exception_return        RTI decoded (fetch from EPC)
//   i_halt                    HALT decoded (stop fetching until reset)
//   i_imem_data, i_imem_done  instruction word / access complete
//   o_imem_rd, o_imem_addr    fetch request and address (combinational)
//   o_inst, o_pc_plus2_out    IF/ID instruction and its PC+2
//   o_inst_valid              IF/ID holds a real fetched instruction
//   o_fetch_stall             fetch waiting on a miss (combinational)
//   o_epc                     saved exception return address
//   o_halted                  fetch permanently stopped
module wisc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002,
  parameter logic [15:0] NOP_INST   = 16'h0800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_exception,
  input  logic        i_exception_return,
  input  logic        i_halt,
  input  logic [15:0] i_imem_data,
  input  logic        i_imem_done,
  output logic        o_imem_rd,
  output logic [15:0] o_imem_addr,
  output logic [15:0] o_inst,
  output logic [15:0] o_pc_plus2_out,
  output logic        o_inst_valid,
  output logic        o_fetch_stall,
  output logic [15:0] o_epc,
  output logic        o_halted
);

  localparam int unsigned W = 16;
  localparam logic [W-1:0] PC_STEP = W'(2);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_pc, w_pc_nxt;
  logic [W-1:0]   r_inst, w_inst_nxt;
  logic [W-1:0]   r_pc_plus2, w_pc_plus2_nxt;
  logic           r_inst_valid, w_inst_valid_nxt;
  logic [W-1:0]   r_epc, w_epc_nxt;
  logic [W-1:0]   r_hold_word, w_hold_word_nxt;
  logic [W-1:0]   r_wait_addr, w_wait_addr_nxt;
  logic           r_drop, w_drop_nxt;
  logic           r_halt_pend, w_halt_pend_nxt;
  logic           r_halted, w_halted_nxt;

  logic           w_redir;
  logic [W-1:0]   w_target_raw;
  logic [W-1:0]   w_target;
  logic           w_req_fetch;

  // Redirect source priority: exception > RTI > branch/jump; targets are halfword aligned.
  assign w_redir      = i_exception | i_exception_return | i_redirect;
  assign w_target_raw = i_exception        ? EXC_VECTOR :
                        i_exception_return ? r_epc      : i_redirect_pc;
  assign w_target     = {w_target_raw[W-1:1], 1'b0};

  // A wrong-path or halted fetch is not requested from FETCH.
  assign w_req_fetch  = ~i_stall & ~i_halt & ~w_redir;

  // Next-state, datapath next values and combinational cache request.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_inst_nxt       = r_inst;
    w_pc_plus2_nxt   = r_pc_plus2;
    w_inst_valid_nxt = r_inst_valid;
    w_epc_nxt        = r_epc;
    w_hold_word_nxt  = r_hold_word;
    w_wait_addr_nxt  = r_wait_addr;
    w_drop_nxt       = r_drop;
    w_halt_pend_nxt  = r_halt_pend;
    w_halted_nxt     = r_halted;
    o_imem_rd        = 1'b0;
    o_imem_addr      = r_pc;
    o_fetch_stall    = 1'b0;

    case (r_state)
      ST_FETCH: begin
        o_imem_rd     = w_req_fetch;
        o_fetch_stall = w_req_fetch & ~i_imem_done;
        if (i_halt) begin
          w_state_nxt      = ST_HALT;
          w_halted_nxt     = 1'b1;
          w_inst_nxt       = NOP_INST;
          w_inst_valid_nxt = 1'b0;
        end else if (w_redir) begin
          w_pc_nxt         = w_target;
          w_inst_nxt       = NOP_INST;
          w_inst_valid_nxt = 1'b0;
          if (i_exception) w_epc_nxt = r_pc_plus2;
        end else if (!i_stall) begin
          if (i_imem_done) begin
            w_inst_nxt       = i_imem_data;
            w_pc_plus2_nxt   = r_pc + PC_STEP;
            w_inst_valid_nxt = 1'b1;
            w_pc_nxt         = r_pc + PC_STEP;
          end else begin
            // Miss: IF/ID takes a bubble while the access is outstanding.
            w_inst_valid_nxt = 1'b0;
            w_wait_addr_nxt  = r_pc;
            w_state_nxt      = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // The outstanding access must run to completion at its original address.
        o_imem_rd     = 1'b1;
        o_imem_addr   = r_wait_addr;
        o_fetch_stall = 1'b1;
        if (i_halt || r_halt_pend) begin
          w_inst_nxt       = NOP_INST;
          w_inst_valid_nxt = 1'b0;
          if (i_imem_done) begin
            w_state_nxt     = ST_HALT;
            w_halted_nxt    = 1'b1;
            w_halt_pend_nxt = 1'b0;
            w_drop_nxt      = 1'b0;
          end else begin
            w_halt_pend_nxt = 1'b1;
          end
        end else begin
          if (w_redir) begin
            w_pc_nxt         = w_target;
            w_inst_nxt       = NOP_INST;
            w_inst_valid_nxt = 1'b0;
            if (i_exception) w_epc_nxt = r_pc_plus2;
          end
          if (i_imem_done) begin
            if (w_redir || r_drop) begin
              // Wrong-path word: throw it away and restart at the new PC.
              w_drop_nxt  = 1'b0;
              w_state_nxt = ST_FETCH;
            end else if (!i_stall) begin
              w_inst_nxt       = i_imem_data;
              w_pc_plus2_nxt   = r_wait_addr + PC_STEP;
              w_inst_valid_nxt = 1'b1;
              w_pc_nxt         = r_wait_addr + PC_STEP;
              w_state_nxt      = ST_FETCH;
            end else begin
              w_hold_word_nxt = i_imem_data;
              w_state_nxt     = ST_HOLD;
            end
          end else if (w_redir) begin
            w_drop_nxt = 1'b1;
          end else if (!i_stall) begin
            w_inst_valid_nxt = 1'b0;
          end
        end
      end

      ST_HOLD: begin
        if (i_halt) begin
          w_state_nxt      = ST_HALT;
          w_halted_nxt     = 1'b1;
          w_inst_nxt       = NOP_INST;
          w_inst_valid_nxt = 1'b0;
        end else if (w_redir) begin
          w_pc_nxt         = w_target;
          w_inst_nxt       = NOP_INST;
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = ST_FETCH;
          if (i_exception) w_epc_nxt = r_pc_plus2;
        end else if (!i_stall) begin
          w_inst_nxt       = r_hold_word;
          w_pc_plus2_nxt   = r_pc + PC_STEP;
          w_inst_valid_nxt = 1'b1;
          w_pc_nxt         = r_pc + PC_STEP;
          w_state_nxt      = ST_FETCH;
        end
      end

      ST_HALT: begin
        // Only reset leaves HALT.
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_inst       <= NOP_INST;
      r_pc_plus2   <= '0;
      r_inst_valid <= 1'b0;
      r_epc        <= '0;
      r_hold_word  <= '0;
      r_wait_addr  <= '0;
      r_drop       <= 1'b0;
      r_halt_pend  <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_inst       <= w_inst_nxt;
      r_pc_plus2   <= w_pc_plus2_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_epc        <= w_epc_nxt;
      r_hold_word  <= w_hold_word_nxt;
      r_wait_addr  <= w_wait_addr_nxt;
      r_drop       <= w_drop_nxt;
      r_halt_pend  <= w_halt_pend_nxt;
      r_halted     <= w_halted_nxt;
    end
  end

  assign o_inst         = r_inst;
  assign o_pc_plus2_out = r_pc_plus2;
  assign o_inst_valid   = r_inst_valid;
  assign o_epc          = r_epc;
  assign o_halted       = r_halted;

endmodule

// File: tb/tb_wisc_fetch_ctrl.sv
// Directed bench for wisc_fetch_ctrl: a flag-based behavioural model of the
// fetch stage checked against the DUT every cycle, plus literal pins.
module tb_wisc_fetch_ctrl;

  localparam logic [15:0] NOP = 16'h0800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, redirect = 1'b0, exception = 1'b0;
  logic        exception_return = 1'b0, halt = 1'b0, imem_done = 1'b0;
  logic [15:0] redirect_pc = 16'h0, imem_data = 16'h0;
  logic        imem_rd, inst_valid, fetch_stall, halted;
  logic [15:0] imem_addr, inst, pc_plus2, epc;

  int checks = 0;
  int failures = 0;

  wisc_fetch_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .i_exception(exception),
    .i_exception_return(exception_return), .i_halt(halt),
    .i_imem_data(imem_data), .i_imem_done(imem_done),
    .o_imem_rd(imem_rd), .o_imem_addr(imem_addr), .o_inst(inst),
    .o_pc_plus2_out(pc_plus2), .o_inst_valid(inst_valid),
    .o_fetch_stall(fetch_stall), .o_epc(epc), .o_halted(halted)
  );

  // Model: an outstanding access (busy), a buffered word, a discard flag.
  typedef struct packed {
    logic [15:0] pc, inst, pc2, epc, busy_addr, buf_word;
    logic valid, halted, busy, buffered, discard, halt_after;
  } mstate_t;

  mstate_t m;
  logic    m_live = 1'b0;

  function automatic logic [15:0] inc2(input logic [15:0] a);
    return a + 16'd2;
  endfunction

  function automatic mstate_t model_reset();
    mstate_t r;
    r = '0;
    r.inst = NOP;
    return r;
  endfunction

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n;
    logic any_redir;
    logic [15:0] tgt;
    n = s;
    any_redir = exception | exception_return | redirect;
    tgt = exception ? 16'h0002 : (exception_return ? s.epc : redirect_pc);
    tgt = tgt & 16'hFFFE;
    if (s.halted) return n;
    if (s.busy) begin
      if (halt || s.halt_after) begin
        n.inst = NOP; n.valid = 1'b0;
        if (imem_done) begin
          n.busy = 1'b0; n.halted = 1'b1; n.halt_after = 1'b0; n.discard = 1'b0;
        end else n.halt_after = 1'b1;
      end else begin
        if (any_redir) begin
          if (exception) n.epc = s.pc2;
          n.pc = tgt; n.inst = NOP; n.valid = 1'b0;
        end
        if (imem_done) begin
          n.busy = 1'b0;
          if (any_redir || s.discard) n.discard = 1'b0;
          else if (!stall) begin
            n.inst = imem_data; n.pc2 = inc2(s.busy_addr);
            n.pc = inc2(s.busy_addr); n.valid = 1'b1;
          end else begin
            n.buffered = 1'b1; n.buf_word = imem_data;
          end
        end else if (any_redir) n.discard = 1'b1;
        else if (!stall) n.valid = 1'b0;
      end
    end else if (halt) begin
      n.halted = 1'b1; n.inst = NOP; n.valid = 1'b0; n.buffered = 1'b0;
    end else if (any_redir) begin
      if (exception) n.epc = s.pc2;
      n.pc = tgt; n.inst = NOP; n.valid = 1'b0; n.buffered = 1'b0;
    end else if (s.buffered) begin
      if (!stall) begin
        n.inst = s.buf_word; n.pc2 = inc2(s.pc); n.pc = inc2(s.pc);
        n.valid = 1'b1; n.buffered = 1'b0;
      end
    end else if (!stall) begin
      if (imem_done) begin
        n.inst = imem_data; n.pc2 = inc2(s.pc); n.pc = inc2(s.pc); n.valid = 1'b1;
      end else begin
        n.busy = 1'b1; n.busy_addr = s.pc; n.valid = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m <= model_reset();
      m_live <= 1'b1;
    end else if (m_live) begin
      m <= model_next(m);
    end
  end

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live && !rst) begin
      logic e_rd, e_fs, any_redir;
      any_redir = exception | exception_return | redirect;
      e_rd = m.halted ? 1'b0 : m.busy ? 1'b1 : m.buffered ? 1'b0 :
             (!stall && !halt && !any_redir);
      e_fs = m.busy | (e_rd & ~imem_done);
      chk1 ("m_imem_rd", imem_rd, e_rd);
      if (e_rd) chk16("m_imem_addr", imem_addr, m.busy ? m.busy_addr : m.pc);
      chk1 ("m_fetch_stall", fetch_stall, e_fs);
      chk16("m_inst", inst, m.inst);
      chk16("m_pc_plus2", pc_plus2, m.pc2);
      chk1 ("m_inst_valid", inst_valid, m.valid);
      chk16("m_epc", epc, m.epc);
      chk1 ("m_halted", halted, m.halted);
    end
  end

  task automatic drive(input logic st, input logic rd, input logic [15:0] rpc,
                       input logic ex, input logic rt, input logic hl,
                       input logic dn, input logic [15:0] dat);
    stall = st; redirect = rd; redirect_pc = rpc; exception = ex;
    exception_return = rt; halt = hl; imem_done = dn; imem_data = dat;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hit: stall=0, done=1 with word
  task automatic hit(input logic [15:0] w);
    drive(0, 0, 16'h0, 0, 0, 0, 1, w);
  endtask

  task automatic miss();
    drive(0, 0, 16'h0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic redir(input logic [15:0] t);
    drive(0, 1, t, 0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk16("rst_inst", inst, NOP);
    chk16("rst_pc2", pc_plus2, 16'h0000);
    chk1 ("rst_valid", inst_valid, 1'b0);
    chk16("rst_epc", epc, 16'h0000);
    chk1 ("rst_halted", halted, 1'b0);

    // Stall in FETCH: no request.
    drive(1, 0, 16'h0, 0, 0, 0, 0, 16'h0);
    chk1("stall_rd", imem_rd, 1'b0); tick();

    // Three hits.
    hit(16'h4101); chk16("hit0_addr", imem_addr, 16'h0000); chk1("hit0_fs", fetch_stall, 1'b0); tick();
    chk16("hit0_inst", inst, 16'h4101); chk16("hit0_pc2", pc_plus2, 16'h0002); chk1("hit0_valid", inst_valid, 1'b1);
    hit(16'h4202); chk16("hit1_addr", imem_addr, 16'h0002); tick();
    chk16("hit1_pc2", pc_plus2, 16'h0004);
    hit(16'h4303); chk16("hit2_addr", imem_addr, 16'h0004); tick();
    chk16("hit2_inst", inst, 16'h4303); chk16("hit2_pc2", pc_plus2, 16'h0006);

    // Miss at 0006 completing on the third request cycle.
    miss(); chk1("miss_fs0", fetch_stall, 1'b1); chk16("miss_addr0", imem_addr, 16'h0006); tick();
    chk1("miss_bubble", inst_valid, 1'b0);
    miss(); chk1("miss_fs1", fetch_stall, 1'b1); chk16("miss_addr1", imem_addr, 16'h0006); tick();
    hit(16'hA5A5); chk1("miss_fs2", fetch_stall, 1'b1); chk16("miss_addr2", imem_addr, 16'h0006); tick();
    chk16("miss_inst", inst, 16'hA5A5); chk16("miss_pc2", pc_plus2, 16'h0008); chk1("miss_valid", inst_valid, 1'b1);

    // Stall across miss completion at 0008, released two cycles later.
    miss(); tick();
    drive(1, 0, 16'h0, 0, 0, 0, 1, 16'hB6B6); tick();
    drive(1, 0, 16'h0, 0, 0, 0, 0, 16'h0); chk1("hold_rd0", imem_rd, 1'b0); tick();
    chk16("hold_inst", inst, 16'hA5A5);
    drive(1, 0, 16'h0, 0, 0, 0, 0, 16'h0); tick();
    drive(0, 0, 16'h0, 0, 0, 0, 0, 16'h0); chk1("hold_rd1", imem_rd, 1'b0); tick();
    chk16("hold_out", inst, 16'hB6B6); chk16("hold_pc2", pc_plus2, 16'h000A); chk1("hold_valid", inst_valid, 1'b1);

    // Redirect while WAIT at 000A; odd target bit is ignored.
    miss(); tick();
    redir(16'h0101); chk16("rdw_addr0", imem_addr, 16'h000A); tick();
    chk16("rdw_nop", inst, NOP); chk1("rdw_valid", inst_valid, 1'b0);
    miss(); chk16("rdw_addr1", imem_addr, 16'h000A); tick();
    hit(16'hDEAD); tick();
    chk16("rdw_drop", inst, NOP);
    hit(16'h1111); chk16("rdw_target", imem_addr, 16'h0100); tick();
    chk16("rdw_inst", inst, 16'h1111); chk16("rdw_pc2", pc_plus2, 16'h0102);

    // Exception with PC+2 0012, simultaneous branch loses; then RTI.
    redir(16'h0010); tick();
    hit(16'h2222); tick();
    chk16("exc_pre_pc2", pc_plus2, 16'h0012);
    drive(0, 1, 16'h0300, 1, 0, 0, 1, 16'hEEEE); chk1("exc_rd", imem_rd, 1'b0); tick();
    chk16("exc_epc", epc, 16'h0012); chk16("exc_nop", inst, NOP);
    hit(16'h3333); chk16("exc_vec", imem_addr, 16'h0002); tick();
    chk16("exc_inst", inst, 16'h3333);
    drive(0, 0, 16'h0, 0, 1, 0, 0, 16'h0); tick();
    hit(16'h4444); chk16("rti_addr", imem_addr, 16'h0012); tick();
    chk16("rti_pc2", pc_plus2, 16'h0014);

    // Wrap from FFFE.
    redir(16'hFFFE); tick();
    hit(16'h5555); chk16("wrap_addr0", imem_addr, 16'hFFFE); tick();
    chk16("wrap_pc2", pc_plus2, 16'h0000);
    hit(16'h6666); chk16("wrap_addr1", imem_addr, 16'h0000); tick();

    // Halt at 0020; nothing but reset restarts fetch.
    redir(16'h0020); tick();
    drive(0, 0, 16'h0, 0, 0, 1, 1, 16'h7777); chk1("halt_rd0", imem_rd, 1'b0); tick();
    chk1("halt_flag", halted, 1'b1); chk16("halt_nop", inst, NOP); chk1("halt_valid", inst_valid, 1'b0);
    redir(16'h0200); chk1("halt_rd1", imem_rd, 1'b0); tick();
    miss(); chk1("halt_rd2", imem_rd, 1'b0); tick();
    chk1("halt_keep", halted, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    hit(16'h8888); chk16("rst2_addr", imem_addr, 16'h0000); chk1("rst2_halted", halted, 1'b0); tick();

    // Halt while a miss at 0002 is outstanding.
    miss(); tick();
    drive(0, 0, 16'h0, 0, 0, 1, 0, 16'h0); chk16("hw_addr", imem_addr, 16'h0002); tick();
    chk16("hw_nop", inst, NOP); chk1("hw_pending", halted, 1'b0);
    hit(16'h9999); chk1("hw_rd", imem_rd, 1'b1); tick();
    chk1("hw_halted", halted, 1'b1); chk16("hw_drop", inst, NOP);
    miss(); chk1("hw_rd_off", imem_rd, 1'b0); tick();

    // Reset in the middle of a miss drops the access.
    rst = 1'b1; tick(); rst = 1'b0;
    miss(); tick();
    rst = 1'b1; hit(16'hBBBB); tick(); rst = 1'b0;
    chk16("rstm_inst", inst, NOP); chk1("rstm_valid", inst_valid, 1'b0);
    hit(16'hAAAA); chk16("rstm_addr", imem_addr, 16'h0000); chk1("rstm_fs", fetch_stall, 1'b0); tick();
    chk16("rstm_out", inst, 16'hAAAA); chk16("rstm_pc2", pc_plus2, 16'h0002);

    miss(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
